// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: pattern modes,
// colour-bar palette and raster timing helpers.
package vga_pkg;

    typedef enum logic [2:0] {
        MODE_BARS  = 3'd0,
        MODE_RAMP  = 3'd1,
        MODE_CHECK = 3'd2,
        MODE_GRID  = 3'd3,
        MODE_FRAME = 3'd4
    } mode_e;

    // Bar colours as {R,G,B} full-on flags.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: pixel-clock divider, horizontal/vertical counters and the
// raw (unregistered) DE/sync/frame-start flags for the current pixel.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int HW       = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pe,
    output logic          pck,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          line_end,
    output logic          de_raw,
    output logic          hs_act,
    output logic          vs_act,
    output logic          frame_first
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SS    = sync_start(H_ACTIVE, H_FP);
    localparam int V_SS    = sync_start(V_ACTIVE, V_FP);
    localparam int DW      = $clog2(CLK_DIV);

    logic [DW-1:0] divcnt;
    logic [DW-1:0] divcnt_nxt;

    assign pe         = (divcnt == DW'(CLK_DIV - 1));
    assign divcnt_nxt = pe ? '0 : divcnt + DW'(1);

    // PCK follows the next divider value so it falls on the edge the
    // outputs change and rises half a pixel later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt <= '0;
            pck    <= 1'b0;
        end else begin
            divcnt <= divcnt_nxt;
            pck    <= (divcnt_nxt >= DW'(CLK_DIV / 2));
        end
    end

    assign line_end = (32'(hcnt) == H_TOTAL - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pe) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= (32'(vcnt) == V_TOTAL - 1) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    assign de_raw      = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
    assign hs_act      = (32'(hcnt) >= H_SS) && (32'(hcnt) < H_SS + H_SYNC);
    assign vs_act      = (32'(vcnt) >= V_SS) && (32'(vcnt) < V_SS + V_SYNC);
    assign frame_first = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: selects one of five patterns per frame and
// registers RGB, sync, DE and frame-start one pixel behind the counters.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 4,
    parameter int   COLOR_W  = 8,
    parameter int   CHK_LOG2 = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [2:0]         MODE,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_DE,
    output logic               PCK,
    output logic               FRAME_START
);

    localparam int HW    = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW    = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic          pe;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          line_end;
    logic          de_raw;
    logic          hs_act;
    logic          vs_act;
    logic          frame_first;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (CLK),
        .rst         (RST),
        .pe          (pe),
        .pck         (PCK),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .line_end    (line_end),
        .de_raw      (de_raw),
        .hs_act      (hs_act),
        .vs_act      (vs_act),
        .frame_first (frame_first)
    );

    // 8-bit frame count left-aligned into COLOR_W (truncated or zero-padded).
    function automatic logic [COLOR_W-1:0] frame_to_color(input logic [7:0] v);
        logic [COLOR_W-1:0] o;
        o = '0;
        for (int i = 0; i < COLOR_W && i < 8; i++) begin
            o[COLOR_W-1-i] = v[7-i];
        end
        return o;
    endfunction

    logic [BW-1:0]      bar_px;
    logic [2:0]         bar_idx;
    logic [2:0]         mode_q;
    logic [7:0]         frame_cnt;
    logic [2:0]         mode_eff;
    logic [7:0]         frame_eff;
    logic [2:0]         bar;
    logic               white;
    logic [COLOR_W-1:0] pat_r;
    logic [COLOR_W-1:0] pat_g;
    logic [COLOR_W-1:0] pat_b;

    // Bar index tracks hcnt with a width counter; bar 7 absorbs the remainder.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pe) begin
            if (line_end) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_idx != 3'd7) begin
                if (bar_px == BW'(BAR_W - 1)) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + BW'(1);
                end
            end
        end
    end

    // The frame-start pixel already uses the newly sampled mode and count.
    always_comb begin
        mode_eff  = frame_first ? MODE : mode_q;
        frame_eff = frame_first ? frame_cnt + 8'd1 : frame_cnt;
        bar       = bar_color(bar_idx);
        white     = 1'b0;
        pat_r     = '0;
        pat_g     = '0;
        pat_b     = '0;
        case (mode_eff)
            MODE_BARS: begin
                pat_r = {COLOR_W{bar[2]}};
                pat_g = {COLOR_W{bar[1]}};
                pat_b = {COLOR_W{bar[0]}};
            end
            MODE_RAMP: begin
                pat_r = COLOR_W'(hcnt);
                pat_g = COLOR_W'(hcnt);
                pat_b = COLOR_W'(hcnt);
            end
            MODE_CHECK: begin
                white = (((32'(hcnt) >> CHK_LOG2) ^ (32'(vcnt) >> CHK_LOG2)) & 32'd1) != 32'd0;
            end
            MODE_GRID: begin
                white = ((32'(hcnt) & 32'h1F) == 32'd0) || ((32'(vcnt) & 32'h1F) == 32'd0) ||
                        (32'(hcnt) == H_ACTIVE - 1) || (32'(vcnt) == V_ACTIVE - 1);
            end
            MODE_FRAME: begin
                pat_r = frame_to_color(frame_eff);
                pat_g = frame_to_color(~frame_eff);
            end
            default: ;
        endcase
        if (white) begin
            pat_r = '1;
            pat_g = '1;
            pat_b = '1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q      <= '0;
            frame_cnt   <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_DE      <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            FRAME_START <= 1'b0;
        end else if (pe) begin
            if (frame_first) begin
                mode_q    <= MODE;
                frame_cnt <= frame_cnt + 8'd1;
            end
            VGA_R       <= de_raw ? pat_r : '0;
            VGA_G       <= de_raw ? pat_g : '0;
            VGA_B       <= de_raw ? pat_b : '0;
            VGA_DE      <= de_raw;
            VGA_HS      <= hs_act ? HS_POL : ~HS_POL;
            VGA_VS      <= vs_act ? VS_POL : ~VS_POL;
            FRAME_START <= frame_first;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a small raster: cycle-by-cycle comparison
// against a pixel-arithmetic model plus directed frame and literal checks.
module tb_vga_pattern_gen;

    localparam int   HA = 20, HFP = 2, HSY = 3, HBP = 2;
    localparam int   VA = 6, VFP = 1, VSY = 2, VBP = 1;
    localparam int   HT = HA + HFP + HSY + HBP;
    localparam int   VT = VA + VFP + VSY + VBP;
    localparam int   FRAME = HT * VT;
    localparam int   CD = 4;
    localparam int   CW = 8;
    localparam int   CHK = 2;
    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    mode;
    logic [CW-1:0] vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_de, pck, frame_start;

    int            checks = 0;
    int            errors = 0;
    int            n_edges = 0;
    int            frame_mode[$];
    logic [28:0]   exp_q[$];
    logic [23:0]   img [VT][HT];

    vga_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .HS_POL   (HS_POL), .VS_POL (VS_POL),
        .CLK_DIV  (CD), .COLOR_W (CW), .CHK_LOG2 (CHK)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .MODE        (mode),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .VGA_DE      (vga_de),
        .PCK         (pck),
        .FRAME_START (frame_start)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) n_edges = 0;
        else     n_edges++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // n = CLK edges since reset release (-1 while in reset); outputs packed
    // as {R,G,B,HS,VS,DE,FRAME_START,PCK}.
    function automatic logic [28:0] expect_at(input int n, input int md, input int fcnt);
        int         k, x, y, bar;
        logic [7:0] r, g, b;
        logic       hs, vs, de, fs, pk, on;
        logic [2:0] bar_rgb [8];
        bar_rgb[0] = 3'b111; bar_rgb[1] = 3'b110; bar_rgb[2] = 3'b011; bar_rgb[3] = 3'b010;
        bar_rgb[4] = 3'b101; bar_rgb[5] = 3'b100; bar_rgb[6] = 3'b001; bar_rgb[7] = 3'b000;
        pk = (n >= 0) && ((n % CD) >= CD / 2);
        if (n < CD) return {24'h0, !HS_POL, !VS_POL, 1'b0, 1'b0, pk};
        k  = n / CD - 1;
        x  = k % HT;
        y  = (k / HT) % VT;
        de = (x < HA) && (y < VA);
        hs = (x >= HA + HFP) && (x < HA + HFP + HSY);
        vs = (y >= VA + VFP) && (y < VA + VFP + VSY);
        fs = (x == 0) && (y == 0);
        r = 8'h00; g = 8'h00; b = 8'h00; on = 1'b0;
        if (de) begin
            case (md)
                0: begin
                    bar = x / (HA / 8);
                    if (bar > 7) bar = 7;
                    r = bar_rgb[bar][2] ? 8'hFF : 8'h00;
                    g = bar_rgb[bar][1] ? 8'hFF : 8'h00;
                    b = bar_rgb[bar][0] ? 8'hFF : 8'h00;
                end
                1: begin r = 8'(x % 256); g = r; b = r; end
                2: on = (((x >> CHK) + (y >> CHK)) % 2) == 1;
                3: on = (x % 32 == 0) || (y % 32 == 0) || (x == HA - 1) || (y == VA - 1);
                4: begin r = 8'(fcnt % 256); g = 8'(255 - fcnt % 256); end
                default: ;
            endcase
            if (on) begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
        end
        return {r, g, b, hs ? HS_POL : !HS_POL, vs ? VS_POL : !VS_POL, de, fs, pk};
    endfunction

    // ---------------- scoreboard: compare every cycle ----------------
    always @(negedge clk) begin
        int          n, k, f, md, kn;
        logic [28:0] want;
        if (rst) begin
            frame_mode.delete();
            want = expect_at(-1, 0, 0);
        end else begin
            n  = n_edges;
            f  = 0;
            md = -1;
            if (n >= CD) begin
                k = n / CD - 1;
                f = k / FRAME;
                if (f < frame_mode.size()) md = frame_mode[f];
            end
            want = expect_at(n, md, f + 1);
            // MODE as seen by the upcoming edge, if that edge starts a frame
            if ((n + 1) % CD == 0) begin
                kn = (n + 1) / CD - 1;
                if (kn % FRAME == 0) frame_mode.push_back(int'(mode));
            end
        end
        exp_q.push_back(want);
        check("raster", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start, pck}),
              32'(exp_q.pop_front()));
    end

    // ---------------- driver tasks ----------------
    task automatic next_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 4 * CD; i++) begin
            prev = pck;
            @(posedge clk); #1;
            if (pck && !prev) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            next_rise(ok);
            if (!ok) return;
            if (frame_start) return;
        end
        ok = 1'b0;
    endtask

    // Samples one whole frame at rising PCK, starting at the next frame start.
    task automatic scan_frame(output bit found, output int de_n, output int de_lines,
                              output int hs_n, output int vs_n, output int fs_n, output bit next_fs);
        bit ok, line_de;
        de_n = 0; de_lines = 0; hs_n = 0; vs_n = 0; fs_n = 0; next_fs = 1'b0; line_de = 1'b0;
        wait_frame_start(found);
        if (!found) return;
        for (int j = 0; j < FRAME; j++) begin
            if (j % HT == 0) line_de = 1'b0;
            img[j / HT][j % HT] = {vga_r, vga_g, vga_b};
            if (vga_de) begin
                de_n++;
                if (!line_de) de_lines++;
                line_de = 1'b1;
            end
            if (vga_hs == HS_POL) hs_n++;
            if (vga_vs == VS_POL) vs_n++;
            if (frame_start) fs_n++;
            next_rise(ok);
            if (!ok) begin found = 1'b0; return; end
        end
        next_fs = frame_start;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          found, next_fs, ok;
        int          de_n, de_lines, hs_n, vs_n, fs_n, cnt;
        logic [7:0]  fr_r [3];
        logic [7:0]  fr_g [3];
        fr_r[0] = 8'h01; fr_r[1] = 8'h02; fr_r[2] = 8'h03;
        fr_g[0] = 8'hFE; fr_g[1] = 8'hFD; fr_g[2] = 8'hFC;

        rst  = 1'b1;
        mode = 3'd0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", 32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start, pck}),
              32'({24'h0, 5'b01000}));
        rst = 1'b0;
        cnt = 0;
        while (pck !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
        check("pck_first_rise_cycles", 32'(cnt), 32'd2);

        // Colour bars frame: structure counts and literal bar colours.
        scan_frame(found, de_n, de_lines, hs_n, vs_n, fs_n, next_fs);
        check("bars_frame_found", 32'(found), 32'd1);
        check("de_pixels_per_frame", 32'(de_n), 32'd120);
        check("de_lines_per_frame", 32'(de_lines), 32'd6);
        check("hs_active_pixels", 32'(hs_n), 32'd30);
        check("vs_active_pixels", 32'(vs_n), 32'd54);
        check("frame_start_count", 32'(fs_n), 32'd1);
        check("frame_period_270", 32'(next_fs), 32'd1);
        check("bar_white_x0", 32'(img[0][0]), 32'hFFFFFF);
        check("bar_yellow_x2", 32'(img[0][2]), 32'hFFFF00);
        check("bar_cyan_x4", 32'(img[0][4]), 32'h00FFFF);
        check("bar_blue_x13", 32'(img[2][13]), 32'h0000FF);
        check("bar_black_x14", 32'(img[3][14]), 32'h000000);
        check("bar_black_x19", 32'(img[5][19]), 32'h000000);
        check("blank_x22", 32'(img[0][22]), 32'h000000);

        // Switch to checkerboard mid-frame; takes effect from the next frame.
        repeat (200) @(posedge clk);
        #1 mode = 3'd2;
        scan_frame(found, de_n, de_lines, hs_n, vs_n, fs_n, next_fs);
        check("check_frame_found", 32'(found), 32'd1);
        check("check_px_4_0", 32'(img[0][4]), 32'hFFFFFF);
        check("check_px_0_0", 32'(img[0][0]), 32'h000000);
        check("check_px_4_4", 32'(img[4][4]), 32'h000000);
        check("check_px_0_4", 32'(img[4][0]), 32'hFFFFFF);

        // Reset mid-frame, then frame-colour mode for three frames.
        repeat (137) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midframe_reset_outputs",
              32'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start, pck}),
              32'({24'h0, 5'b01000}));
        mode = 3'd4;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_frame_start(ok);
            check("frame_mode_found", 32'(ok), 32'd1);
            check("frame_mode_r", 32'(vga_r), 32'(fr_r[f]));
            check("frame_mode_g", 32'(vga_g), 32'(fr_g[f]));
        end

        // Random mode changes and occasional reset pulses.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(20, 400)) @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                mode = 3'($urandom_range(0, 7));
            end
        end

        repeat (20) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
